noc_link_tx_ctrl: RTL and testbench



---
 rtl/noc_link_tx_ctrl_pkg.sv | 34 +++
 rtl/noc_link_tx_ctrl_if.sv | 54 +++++
 rtl/noc_link_tx_buf.sv | 59 +++++
 rtl/noc_link_tx_ctrl.sv | 129 ++++++++++++
 tb/tb_noc_link_tx_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/noc_link_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx_ctrl_pkg
// Description : Shared widths, header field positions and FSM encodings for
//               the NoC link transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_link_tx_ctrl_pkg;

    // Link flit geometry
    localparam int NOC_HEADER_SIZE      = 16;
    localparam int NOC_PAYLOAD_SIZE     = 32;
    localparam int NOC_HEADER_BURST_BIT = 15;
    localparam int STAT_WIDTH           = 32;
    localparam int FLIT_WIDTH           = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE;

    // FSM encodings
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_LOCK0 = 2'd1;
    localparam logic [1:0] C_ST_LOCK1 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_LOCK0 = C_ST_LOCK0,
        ST_LOCK1 = C_ST_LOCK1
    } tx_state_e;

    // A set burst bit means more flits of the same burst follow
    function automatic logic is_burst(input logic [NOC_HEADER_SIZE-1:0] hdr);
        return hdr[NOC_HEADER_BURST_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_link_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx_ctrl_if
// Description : Source handshakes, PHY write port and statistics of the NoC
//               link transmit controller. The controller uses "slave", the
//               surrounding router/PHY side uses "master".
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_link_tx_ctrl_if;
    import noc_link_tx_ctrl_pkg::*;

    logic                        src0_valid_i;
    logic [NOC_HEADER_SIZE-1:0]  src0_header_i;
    logic [NOC_PAYLOAD_SIZE-1:0] src0_payload_i;
    logic                        src0_ready_o;

    logic                        src1_valid_i;
    logic [NOC_HEADER_SIZE-1:0]  src1_header_i;
    logic [NOC_PAYLOAD_SIZE-1:0] src1_payload_i;
    logic                        src1_ready_o;

    logic                        tx_wrreq_o;
    logic [NOC_HEADER_SIZE-1:0]  tx_header_o;
    logic [NOC_PAYLOAD_SIZE-1:0] tx_payload_o;
    logic                        tx_stall_i;

    logic                        stats_clr_i;
    logic [STAT_WIDTH-1:0]       flit_cnt_o;
    logic [STAT_WIDTH-1:0]       stall_cnt_o;

    modport slave (
        input  src0_valid_i, src0_header_i, src0_payload_i,
        output src0_ready_o,
        input  src1_valid_i, src1_header_i, src1_payload_i,
        output src1_ready_o,
        output tx_wrreq_o, tx_header_o, tx_payload_o,
        input  tx_stall_i,
        input  stats_clr_i,
        output flit_cnt_o, stall_cnt_o
    );

    modport master (
        output src0_valid_i, src0_header_i, src0_payload_i,
        input  src0_ready_o,
        output src1_valid_i, src1_header_i, src1_payload_i,
        input  src1_ready_o,
        input  tx_wrreq_o, tx_header_o, tx_payload_o,
        output tx_stall_i,
        output stats_clr_i,
        input  flit_cnt_o, stall_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/noc_link_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx_buf
// Description : 2-entry synchronous FIFO with a registered head entry.
//               Simultaneous push and pop keep the occupancy unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_link_tx_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail;
    logic             do_push;
    logic             do_pop;

    // Ignore pops when empty and pushes when full with no room being freed
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // Head/tail storage and occupancy update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_link_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_tx_ctrl
// Description : Transmit-side link driver. Round-robin arbitration between a
//               local (src0) and a through-traffic (src1) source, bursts held
//               on one source until their last flit, and a 2-entry buffer
//               decoupling the sources from PHY back-pressure.
//               Optional statistics counters: NOC_LINK_TX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_link_tx_ctrl
    import noc_link_tx_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    noc_link_tx_ctrl_if.slave link
);

    tx_state_e             state, state_nxt;
    logic                  rr_prio, rr_prio_nxt;
    logic                  grant0, grant1;
    logic                  space;
    logic                  acc0, acc1;
    logic                  push, pop;
    logic [1:0]            count;
    logic [FLIT_WIDTH-1:0] push_data;
    logic [FLIT_WIDTH-1:0] head;

    // Arbitration state: current lock and round-robin preference
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            rr_prio <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_prio <= rr_prio_nxt;
        end
    end

    // Grant selection, accept detection and next-state logic
    always_comb begin
        state_nxt   = state;
        rr_prio_nxt = rr_prio;
        grant0      = 1'b0;
        grant1      = 1'b0;
        // Ready depends only on registered occupancy, never on tx_stall_i
        space       = (count != 2'd2);
        acc0        = 1'b0;
        acc1        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (link.src0_valid_i && (!link.src1_valid_i || !rr_prio))
                    grant0 = 1'b1;
                else if (link.src1_valid_i)
                    grant1 = 1'b1;
                acc0 = grant0 && space && link.src0_valid_i;
                acc1 = grant1 && space && link.src1_valid_i;
                if (acc0) begin
                    rr_prio_nxt = 1'b1;
                    if (is_burst(link.src0_header_i)) state_nxt = ST_LOCK0;
                end else if (acc1) begin
                    rr_prio_nxt = 1'b0;
                    if (is_burst(link.src1_header_i)) state_nxt = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                grant0 = 1'b1;
                acc0   = space && link.src0_valid_i;
                if (acc0 && !is_burst(link.src0_header_i)) state_nxt = ST_IDLE;
            end
            ST_LOCK1: begin
                grant1 = 1'b1;
                acc1   = space && link.src1_valid_i;
                if (acc1 && !is_burst(link.src1_header_i)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign link.src0_ready_o = grant0 && space;
    assign link.src1_ready_o = grant1 && space;

    assign push      = acc0 || acc1;
    assign push_data = acc0 ? {link.src0_header_i, link.src0_payload_i}
                            : {link.src1_header_i, link.src1_payload_i};
    assign pop       = (count != 2'd0) && !link.tx_stall_i;

    noc_link_tx_buf #(
        .WIDTH(FLIT_WIDTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign link.tx_wrreq_o   = pop;
    assign link.tx_header_o  = head[FLIT_WIDTH-1:NOC_PAYLOAD_SIZE];
    assign link.tx_payload_o = head[NOC_PAYLOAD_SIZE-1:0];

`ifdef NOC_LINK_TX_STATS_EN
    logic [STAT_WIDTH-1:0] flit_cnt;
    logic [STAT_WIDTH-1:0] stall_cnt;

    // Written-flit and stalled-cycle counters; clear wins over increment
    always_ff @(posedge clk_i) begin
        if (rst_i || link.stats_clr_i) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop)
                flit_cnt <= flit_cnt + STAT_WIDTH'(1);
            if ((count != 2'd0) && link.tx_stall_i)
                stall_cnt <= stall_cnt + STAT_WIDTH'(1);
        end
    end

    assign link.flit_cnt_o  = flit_cnt;
    assign link.stall_cnt_o = stall_cnt;
`else
    assign link.flit_cnt_o  = '0;
    assign link.stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_link_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_link_tx_ctrl
// Description : Directed testbench; expected PHY flits are queued by the
//               stimulus and consumed by an independent write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_link_tx_ctrl;
    import noc_link_tx_ctrl_pkg::*;

    typedef logic [NOC_HEADER_SIZE-1:0]  hdr_t;
    typedef logic [NOC_PAYLOAD_SIZE-1:0] pld_t;

`ifdef NOC_LINK_TX_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    noc_link_tx_ctrl_if link_if();

    noc_link_tx_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .link  (link_if)
    );

    int                    n_checks = 0;
    int                    n_fails  = 0;
    logic [FLIT_WIDTH-1:0] exp_q[$];
    logic [FLIT_WIDTH-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every PHY write must match the next expected flit
    always @(negedge clk) begin
        if (link_if.tx_wrreq_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL phy_unexpected_write: got 0x%0h, expected no write (t=%0t)",
                         {link_if.tx_header_o, link_if.tx_payload_o}, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("phy_flit", 64'({link_if.tx_header_o, link_if.tx_payload_o}), 64'(mon_exp));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input hdr_t h0, input pld_t p0,
                         input logic v1, input hdr_t h1, input pld_t p1,
                         input logic stall);
        link_if.src0_valid_i   = v0;
        link_if.src0_header_i  = h0;
        link_if.src0_payload_i = p0;
        link_if.src1_valid_i   = v1;
        link_if.src1_header_i  = h1;
        link_if.src1_payload_i = p1;
        link_if.tx_stall_i     = stall;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Checks readies and write strobe at the negedge of the current cycle
    task automatic chk(input string tag, input logic r0, input logic r1, input logic wr);
        @(negedge clk);
        check({tag, "_rdy0"},  64'(link_if.src0_ready_o), 64'(r0));
        check({tag, "_rdy1"},  64'(link_if.src1_ready_o), 64'(r1));
        check({tag, "_wrreq"}, 64'(link_if.tx_wrreq_o),   64'(wr));
    endtask

    task automatic do_reset();
        idle();
        link_if.stats_clr_i = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        link_if.stats_clr_i = 1'b0;
        idle();
        do_reset();

        // Reset state
        chk("reset", 1'b0, 1'b0, 1'b0);
        check("reset_header",  64'(link_if.tx_header_o),  64'd0);
        check("reset_payload", 64'(link_if.tx_payload_o), 64'd0);
        check("reset_flitcnt", 64'(link_if.flit_cnt_o),   64'd0);
        check("reset_stallcnt",64'(link_if.stall_cnt_o),  64'd0);
        next_cycle();

        // Single flit from src0, written one cycle after accept
        exp_q.push_back({16'h0001, 32'h0000_00A5});
        drive(1'b1, 16'h0001, 32'h0000_00A5, 1'b0, '0, '0, 1'b0);
        chk("single_c0", 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle();
        chk("single_c1", 1'b0, 1'b0, 1'b1);
        next_cycle();
        chk("single_c2", 1'b0, 1'b0, 1'b0);
        check("single_flitcnt", 64'(link_if.flit_cnt_o), 64'(STATS_ON));
        next_cycle();

        // Both sources valid with single flits: alternate, one write per cycle
        do_reset();
        exp_q.push_back({16'h0002, 32'h100});
        exp_q.push_back({16'h0012, 32'h200});
        exp_q.push_back({16'h0002, 32'h101});
        exp_q.push_back({16'h0012, 32'h201});
        drive(1'b1, 16'h0002, 32'h100, 1'b1, 16'h0012, 32'h200, 1'b0);
        chk("rr_c0", 1'b1, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 16'h0002, 32'h101, 1'b1, 16'h0012, 32'h200, 1'b0);
        chk("rr_c1", 1'b0, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 16'h0002, 32'h101, 1'b1, 16'h0012, 32'h201, 1'b0);
        chk("rr_c2", 1'b1, 1'b0, 1'b1); next_cycle();
        drive(1'b1, 16'h0002, 32'h102, 1'b1, 16'h0012, 32'h201, 1'b0);
        chk("rr_c3", 1'b0, 1'b1, 1'b1); next_cycle();
        idle();
        chk("rr_c4", 1'b0, 1'b0, 1'b1); next_cycle();
        chk("rr_c5", 1'b0, 1'b0, 1'b0); next_cycle();

        // src1 3-flit burst with a 2-cycle gap; src0 locked out until last flit
        do_reset();
        exp_q.push_back({16'h8011, 32'hB1});
        exp_q.push_back({16'h8011, 32'hB2});
        exp_q.push_back({16'h0011, 32'hB3});
        exp_q.push_back({16'h0003, 32'hC0});
        drive(1'b0, '0, '0, 1'b1, 16'h8011, 32'hB1, 1'b0);
        chk("burst_c0", 1'b0, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 16'h0003, 32'hC0, 1'b0, '0, '0, 1'b0);
        chk("burst_c1", 1'b0, 1'b1, 1'b1); next_cycle();
        chk("burst_c2", 1'b0, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 16'h0003, 32'hC0, 1'b1, 16'h8011, 32'hB2, 1'b0);
        chk("burst_c3", 1'b0, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 16'h0003, 32'hC0, 1'b1, 16'h0011, 32'hB3, 1'b0);
        chk("burst_c4", 1'b0, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 16'h0003, 32'hC0, 1'b0, '0, '0, 1'b0);
        chk("burst_c5", 1'b1, 1'b0, 1'b1); next_cycle();
        idle();
        chk("burst_c6", 1'b0, 1'b0, 1'b1); next_cycle();
        chk("burst_c7", 1'b0, 1'b0, 1'b0); next_cycle();

        // PHY stall for 5 cycles while src0 streams: buffer fills, readies drop
        do_reset();
        exp_q.push_back({16'h0004, 32'hD0});
        exp_q.push_back({16'h0004, 32'hD1});
        drive(1'b1, 16'h0004, 32'hD0, 1'b0, '0, '0, 1'b0);
        chk("stall_c0", 1'b1, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 16'h0004, 32'hD1, 1'b0, '0, '0, 1'b1);
        chk("stall_c1", 1'b1, 1'b0, 1'b0); next_cycle();
        for (int i = 2; i <= 5; i++) begin
            drive(1'b1, 16'h0004, 32'hD2, 1'b0, '0, '0, 1'b1);
            chk("stall_full", 1'b0, 1'b0, 1'b0); next_cycle();
        end
        idle();
        chk("stall_c6", 1'b0, 1'b0, 1'b1);
        check("stall_cnt", 64'(link_if.stall_cnt_o), 64'(5 * STATS_ON));
        next_cycle();
        chk("stall_c7", 1'b0, 1'b0, 1'b1); next_cycle();
        chk("stall_c8", 1'b0, 1'b0, 1'b0);
        check("stall_flitcnt", 64'(link_if.flit_cnt_o), 64'(2 * STATS_ON));
        next_cycle();

        // Reset mid-burst with 2 buffered flits: both discarded, src1 wins
        do_reset();
        exp_q.push_back({16'h0006, 32'hF0});
        drive(1'b1, 16'h8005, 32'hE0, 1'b0, '0, '0, 1'b1);
        chk("rstmid_c0", 1'b1, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 16'h8005, 32'hE1, 1'b1, 16'h0006, 32'hF0, 1'b1);
        chk("rstmid_c1", 1'b1, 1'b0, 1'b0); next_cycle();
        drive(1'b0, '0, '0, 1'b1, 16'h0006, 32'hF0, 1'b1);
        chk("rstmid_c2", 1'b0, 1'b0, 1'b0); next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 16'h0006, 32'hF0, 1'b0);
        chk("rstmid_c4", 1'b0, 1'b1, 1'b0);
        check("rstmid_stallcnt", 64'(link_if.stall_cnt_o), 64'd0);
        next_cycle();
        idle();
        chk("rstmid_c5", 1'b0, 1'b0, 1'b1); next_cycle();
        chk("rstmid_c6", 1'b0, 1'b0, 1'b0); next_cycle();

        // Statistics clear coincident with a write
        do_reset();
        exp_q.push_back({16'h0007, 32'h77});
        drive(1'b1, 16'h0007, 32'h77, 1'b0, '0, '0, 1'b0);
        chk("clr_c0", 1'b1, 1'b0, 1'b0); next_cycle();
        idle();
        link_if.stats_clr_i = 1'b1;
        chk("clr_c1", 1'b0, 1'b0, 1'b1); next_cycle();
        link_if.stats_clr_i = 1'b0;
        @(negedge clk);
        check("clr_flitcnt", 64'(link_if.flit_cnt_o), 64'd0);
        next_cycle();

        repeat (3) next_cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
